// File: rtl/logic_unit_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | logic_unit_sched_if : request/grant/result bundle for logic_unit_sched     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface logic_unit_sched_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     op;
  logic [WIDTH*N_REQ-1:0] a_in;
  logic [WIDTH*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   res_valid;
  logic [IDW-1:0]         res_id;
  logic [WIDTH-1:0]       res_data;
  logic [CNT_W-1:0]       op_cnt;

  modport master (
    output req, op, a_in, b_in,
    input  gnt, busy, res_valid, res_id, res_data, op_cnt
  );

  modport slave (
    input  req, op, a_in, b_in,
    output gnt, busy, res_valid, res_id, res_data, op_cnt
  );
endinterface
`default_nettype wire

// File: rtl/logic_unit_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | logic_unit_sched : round-robin sharing of one NAND-built logic unit        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module logic_unit_sched #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  logic_unit_sched_if.slave  bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   cur_id_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [N_REQ-1:0] gnt_q;
  logic             busy_q;
  logic             res_valid_q;
  logic [IDW-1:0]   res_id_q;
  logic [WIDTH-1:0] res_data_q;
  logic [CNT_W-1:0] op_cnt_q;

  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [N_REQ-1:0] win_gnt;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;

  // Search order starts one past the last winner and wraps around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_gnt   = '0;
    win_op    = '0;
    win_a     = '0;
    win_b     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!win_found && (i == (int'(ptr_q) + k) % N_REQ) && bus.req[i]) begin
          win_found = 1'b1;
          win_id    = IDW'(i);
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_gnt[i] = 1'b1;
        win_op     = bus.op[2*i +: 2];
        win_a      = bus.a_in[WIDTH*i +: WIDTH];
        win_b      = bus.b_in[WIDTH*i +: WIDTH];
      end
    end
  end

  wire [WIDTH-1:0] and_w;
  wire [WIDTH-1:0] or_w;
  wire [WIDTH-1:0] not_w;
  wire [WIDTH-1:0] xor_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    wire n_ab, n_aa, n_bb, n_a_nb, n_na_b, x1, x2, n_x1, n_x2;
    nand u_ab   (n_ab,     a_q[i], b_q[i]);
    nand u_and  (and_w[i], n_ab,   n_ab);
    nand u_aa   (n_aa,     a_q[i], a_q[i]);
    nand u_bb   (n_bb,     b_q[i], b_q[i]);
    nand u_or   (or_w[i],  n_aa,   n_bb);
    nand u_not  (not_w[i], a_q[i], a_q[i]);
    // XOR is built as (a & ~b) | (~a & b), each term and the OR in NAND form.
    nand u_anb  (n_a_nb,   a_q[i], n_bb);
    nand u_x1   (x1,       n_a_nb, n_a_nb);
    nand u_nab  (n_na_b,   n_aa,   b_q[i]);
    nand u_x2   (x2,       n_na_b, n_na_b);
    nand u_nx1  (n_x1,     x1,     x1);
    nand u_nx2  (n_x2,     x2,     x2);
    nand u_xor  (xor_w[i], n_x1,   n_x2);
  end

  logic [WIDTH-1:0] unit_res;

  always_comb begin
    unit_res = and_w;
    case (op_q)
      2'b01:   unit_res = or_w;
      2'b10:   unit_res = not_w;
      2'b11:   unit_res = xor_w;
      default: unit_res = and_w;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(N_REQ - 1);
      cur_id_q    <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      op_cnt_q    <= '0;
    end else begin
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            op_q     <= win_op;
            a_q      <= win_a;
            b_q      <= win_b;
            cur_id_q <= win_id;
            ptr_q    <= win_id;
            gnt_q    <= win_gnt;
            busy_q   <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          res_data_q  <= unit_res;
          res_id_q    <= cur_id_q;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          op_cnt_q <= op_cnt_q + 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;
  assign bus.op_cnt    = op_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_logic_unit_sched : randomized bench with behavioural scheduler model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_logic_unit_sched;
  localparam int WIDTH = 8;
  localparam int N_REQ = 4;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;

  logic_unit_sched_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

  logic_unit_sched #(.WIDTH(WIDTH), .N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Requester-side state: what each requester is currently presenting.
  logic [N_REQ-1:0] cur_req;
  logic [1:0]       st_op [N_REQ];
  logic [WIDTH-1:0] st_a  [N_REQ];
  logic [WIDTH-1:0] st_b  [N_REQ];

  // Reference model state.
  int               m_ptr;
  int               m_cnt;
  logic [WIDTH-1:0] m_data;
  int               m_id;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N_REQ-1:0] m);
    for (int i = ptr + 1; i < ptr + 1 + N_REQ; i++)
      if (m[i % N_REQ]) return i % N_REQ;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] alu_ref(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (o)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~a;
      default: return a ^ b;
    endcase
  endfunction

  task automatic drive();
    bus.req = cur_req;
    for (int i = 0; i < N_REQ; i++) begin
      bus.op[2*i +: 2]         = st_op[i];
      bus.a_in[WIDTH*i +: WIDTH] = st_a[i];
      bus.b_in[WIDTH*i +: WIDTH] = st_b[i];
    end
  endtask

  task automatic rand_slot(input int i);
    st_op[i] = 2'($urandom);
    st_a[i]  = WIDTH'($urandom);
    st_b[i]  = WIDTH'($urandom);
  endtask

  task automatic model_reset();
    m_ptr  = N_REQ - 1;
    m_cnt  = 0;
    m_data = '0;
    m_id   = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},  32'(bus.gnt),       32'd0);
    check({tag, "_busy"}, 32'(bus.busy),      32'd0);
    check({tag, "_rv"},   32'(bus.res_valid), 32'd0);
    check({tag, "_id"},   32'(bus.res_id),    32'd0);
    check({tag, "_data"}, 32'(bus.res_data),  32'd0);
    check({tag, "_cnt"},  32'(bus.op_cnt),    32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n   = 1'b0;
    cur_req = N_REQ'($urandom);
    for (int i = 0; i < N_REQ; i++) rand_slot(i);
    drive();
    repeat (cycles) begin
      @(posedge clk); #1;
      check_zero("rst");
    end
    cur_req = '0;
    drive();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("idle_gnt",  32'(bus.gnt),       32'd0);
    check("idle_busy", 32'(bus.busy),      32'd0);
    check("idle_rv",   32'(bus.res_valid), 32'd0);
    check("idle_data", 32'(bus.res_data),  32'(m_data));
    check("idle_id",   32'(bus.res_id),    32'(m_id));
    check("idle_cnt",  32'(bus.op_cnt),    32'(m_cnt));
  endtask

  // One full transaction starting from IDLE with cur_req already driven.
  task automatic run_op(input bit hold, output logic [WIDTH-1:0] got_d, output int got_id);
    int               w;
    logic [WIDTH-1:0] exp_d;
    w     = rr_pick(m_ptr, cur_req);
    exp_d = alu_ref(st_op[w], st_a[w], st_b[w]);
    @(posedge clk); #1;
    check("gnt",       32'(bus.gnt),       32'd1 << w);
    check("busy_exec", 32'(bus.busy),      32'd1);
    check("rv_exec",   32'(bus.res_valid), 32'd0);
    check("data_hold", 32'(bus.res_data),  32'(m_data));
    if (!hold) begin
      cur_req[w] = 1'b0;
      rand_slot(w);
      drive();
    end
    @(posedge clk); #1;
    check("gnt_resp",  32'(bus.gnt),       32'd0);
    check("rv_resp",   32'(bus.res_valid), 32'd1);
    check("res_data",  32'(bus.res_data),  32'(exp_d));
    check("res_id",    32'(bus.res_id),    32'(w));
    check("busy_resp", 32'(bus.busy),      32'd1);
    check("cnt_resp",  32'(bus.op_cnt),    32'(m_cnt));
    got_d  = bus.res_data;
    got_id = int'(bus.res_id);
    m_cnt  = (m_cnt + 1) % (1 << CNT_W);
    m_ptr  = w;
    m_data = exp_d;
    m_id   = w;
    @(posedge clk); #1;
    check("rv_after",   32'(bus.res_valid), 32'd0);
    check("busy_after", 32'(bus.busy),      32'd0);
    check("gnt_after",  32'(bus.gnt),       32'd0);
    check("cnt_after",  32'(bus.op_cnt),    32'(m_cnt));
    check("data_after", 32'(bus.res_data),  32'(m_data));
  endtask

  logic [WIDTH-1:0] gd;
  int               gi;
  logic [N_REQ-1:0] nw;
  logic [WIDTH-1:0] fair_d [5] = '{8'h30, 8'hFC, 8'h0F, 8'hCC, 8'h30};

  initial begin
    rst_n = 1'b0;
    model_reset();

    // Reset with random inputs, then a quiet period.
    do_reset(3);
    repeat (5) idle_cycle();

    // Single XOR from requester 2.
    cur_req = 4'b0100;
    st_op[2] = 2'b11; st_a[2] = 8'hA5; st_b[2] = 8'h0F;
    drive();
    run_op(1'b0, gd, gi);
    check("xor_data", 32'(gd), 32'h0000_00AA);
    check("xor_id",   32'(gi), 32'd2);
    check("xor_cnt",  32'(bus.op_cnt), 32'd1);

    // Fairness under a constantly asserted request vector.
    do_reset(1);
    cur_req = 4'b1111;
    for (int i = 0; i < N_REQ; i++) begin
      st_op[i] = 2'(i); st_a[i] = 8'hF0; st_b[i] = 8'h3C;
    end
    drive();
    for (int k = 0; k < 5; k++) begin
      run_op(1'b1, gd, gi);
      check("fair_data", 32'(gd), 32'(fair_d[k]));
      check("fair_id",   32'(gi), 32'(k % N_REQ));
    end

    // NOT ignores b, then a lone request from 3 is served next.
    cur_req = 4'b0010;
    st_op[1] = 2'b10; st_a[1] = 8'h3C; st_b[1] = 8'hFF;
    drive();
    run_op(1'b0, gd, gi);
    check("not_data", 32'(gd), 32'h0000_00C3);
    check("not_id",   32'(gi), 32'd1);
    cur_req = 4'b1000;
    rand_slot(3);
    drive();
    run_op(1'b0, gd, gi);
    check("lone3_id", 32'(gi), 32'd3);

    // Reset while the operation is in EXEC.
    cur_req = 4'b0100;
    rand_slot(2);
    drive();
    @(posedge clk); #1;
    check("mid_gnt", 32'(bus.gnt), 32'b0100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rv",   32'(bus.res_valid), 32'd0);
    check("mid_cnt",  32'(bus.op_cnt),    32'd0);
    check("mid_busy", 32'(bus.busy),      32'd0);
    model_reset();
    cur_req = 4'b1010;
    rand_slot(1); rand_slot(3);
    drive();
    rst_n = 1'b1;
    run_op(1'b0, gd, gi);
    check("post_rst_id", 32'(gi), 32'd1);

    // Random traffic with persistent pending requests.
    for (int it = 0; it < 150; it++) begin
      nw = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      if ($urandom_range(0, 3) == 0) nw = '0;
      for (int i = 0; i < N_REQ; i++) begin
        if (nw[i] && !cur_req[i]) begin
          cur_req[i] = 1'b1;
          rand_slot(i);
        end
      end
      drive();
      if (cur_req == '0) idle_cycle();
      else run_op(1'b0, gd, gi);
    end

    // Counter wrap over 16 operations.
    do_reset(1);
    for (int n = 0; n < 16; n++) begin
      if (cur_req == '0) begin
        gi = $urandom_range(0, N_REQ - 1);
        cur_req[gi] = 1'b1;
        rand_slot(gi);
      end
      drive();
      run_op(1'b0, gd, gi);
      if (n == 14) check("wrap15", 32'(bus.op_cnt), 32'd15);
      if (n == 15) check("wrap0",  32'(bus.op_cnt), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
